// File: rtl/oam_dma.sv
// oam_dma -- OAM DMA bus initiator.
// A CPU store to REG_ADDR latches a source page and starts copying LENGTH
// bytes from {page,8'h00}.. into OAM index 0..LENGTH-1, one byte per
// READ/WRITE pair of cycles, after a single START cycle.
// Ports:
//   clock4, resetn            clock, synchronous active-low reset
//   cpu_address/indata/store  CPU store bus (trigger + register write)
//   reg_data                  readback of last value stored to REG_ADDR
//   dma_active                transfer in progress (arbiter hold-off)
//   dma_address/load, rdata   memory bus load side
//   oam_address/data/store    OAM write port
//   dma_done                  one-cycle pulse after the final OAM write
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hFF46,
  parameter int          LENGTH   = 160
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_indata,
  input  logic        cpu_store,
  output logic [7:0]  reg_data,
  output logic        dma_active,
  output logic [15:0] dma_address,
  output logic        dma_load,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  oam_address,
  output logic [7:0]  oam_data,
  output logic        oam_store,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t     state, state_nxt;
  logic [7:0] page, idx, data_q;
  logic       trig, last;

  assign trig = cpu_store && (cpu_address == REG_ADDR);
  assign last = (idx == LAST_IDX);

  // state register
  always_ff @(posedge clock4) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state; a trigger restarts from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      START:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
    if (trig) state_nxt = START;
  end

  // datapath registers
  always_ff @(posedge clock4) begin
    if (!resetn) begin
      page     <= 8'h00;
      idx      <= 8'h00;
      reg_data <= 8'h00;
      data_q   <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      if (state == READ) data_q <= dma_rdata;
      // a restart on the final WRITE edge swallows the done pulse
      dma_done <= (state == WRITE) && last && !trig;
      if (trig) begin
        page     <= cpu_indata;
        reg_data <= cpu_indata;
        idx      <= 8'h00;
      end else if (state == WRITE && !last) begin
        idx <= idx + 8'h01;
      end
    end
  end

  // Moore outputs; load and store live in different states so never overlap
  always_comb begin
    dma_active  = 1'b0;
    dma_load    = 1'b0;
    dma_address = 16'h0000;
    oam_store   = 1'b0;
    oam_address = 8'h00;
    oam_data    = 8'h00;
    case (state)
      START: dma_active = 1'b1;
      READ: begin
        dma_active  = 1'b1;
        dma_load    = 1'b1;
        dma_address = {page, idx};  // no carry into page by construction
      end
      WRITE: begin
        dma_active  = 1'b1;
        oam_store   = 1'b1;
        oam_address = idx;
        oam_data    = data_q;
      end
      default: ;
    endcase
  end

endmodule
